// File: rtl/gtp_tx_framer.sv
// Frames FIFO payload for a GTP transmitter: IDLE comma words between frames,
// SOF, FRAME_LEN payload words read straight from the FIFO, then EOF.
module gtp_tx_framer #(
    parameter int FRAME_LEN = 8,
    parameter int CNT_W     = 10
) (
    input  logic             gtp_clk,
    input  logic             reset_n,
    input  logic             link_ready,
    input  logic [CNT_W-1:0] fifo_count,
    input  logic [15:0]      fifo_dout,
    output logic             fifo_rd_en,
    output logic [15:0]      txdata,
    output logic [1:0]       txcharisk,
    output logic             busy,
    output logic [15:0]      frames_sent,
    output logic [1:0]       dbg_state_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2,
        S_EOF   = 2'd3
    } state_t;

    localparam logic [15:0]      IDLE_WORD = 16'h50BC;
    localparam logic [15:0]      SOF_WORD  = 16'h00FB;
    localparam logic [15:0]      EOF_WORD  = 16'h00FD;
    localparam logic [1:0]       K_LOW     = 2'b01;
    localparam logic [1:0]       K_NONE    = 2'b00;
    localparam logic [7:0]       LAST_RD   = 8'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] NEED_CNT  = CNT_W'(FRAME_LEN);

    // Handshake: fifo_rd_en is a strobe with no back-pressure; the word it
    // requests is valid on fifo_dout during the cycle after the strobe.

    logic [1:0]  rst_sync_q;
    logic        run;
    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        rd_en_q, rd_en_d;
    logic [15:0] tx_q, tx_d;
    logic [1:0]  k_q, k_d;
    logic        busy_q, busy_d;
    logic [15:0] frames_q, frames_d;

    // The FSM only starts moving once the released reset has passed two flops.
    always_ff @(posedge gtp_clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign run = rst_sync_q[1];

    always_ff @(posedge gtp_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= 8'd0;
            rd_en_q  <= 1'b0;
            tx_q     <= IDLE_WORD;
            k_q      <= K_LOW;
            busy_q   <= 1'b0;
            frames_q <= 16'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rd_en_q  <= rd_en_d;
            tx_q     <= tx_d;
            k_q      <= k_d;
            busy_q   <= busy_d;
            frames_q <= frames_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rd_en_d  = 1'b0;
        tx_d     = IDLE_WORD;
        k_d      = K_LOW;
        busy_d   = 1'b0;
        frames_d = frames_q;

        // busy still high while back in IDLE means EOF is on the wire right now.
        if (busy_q && (state_q == S_IDLE)) begin
            frames_d = frames_q + 16'd1;
        end

        if (run) begin
            case (state_q)
                S_IDLE: begin
                    if (link_ready && (fifo_count >= NEED_CNT)) begin
                        state_d = S_READ;
                        cnt_d   = 8'd0;
                        rd_en_d = 1'b1;
                    end
                end
                S_READ: begin
                    busy_d = 1'b1;
                    if (cnt_q == 8'd0) begin
                        tx_d = SOF_WORD;
                        k_d  = K_LOW;
                    end else begin
                        tx_d = fifo_dout;
                        k_d  = K_NONE;
                    end
                    if (cnt_q == LAST_RD) begin
                        state_d = S_DRAIN;
                    end else begin
                        rd_en_d = 1'b1;
                        cnt_d   = cnt_q + 8'd1;
                    end
                end
                S_DRAIN: begin
                    busy_d  = 1'b1;
                    tx_d    = fifo_dout;
                    k_d     = K_NONE;
                    state_d = S_EOF;
                end
                S_EOF: begin
                    busy_d  = 1'b1;
                    tx_d    = EOF_WORD;
                    k_d     = K_LOW;
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    assign fifo_rd_en  = rd_en_q;
    assign txdata      = tx_q;
    assign txcharisk   = k_q;
    assign busy        = busy_q;
    assign frames_sent = frames_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_gtp_tx_framer.sv
// Bench for gtp_tx_framer (FRAME_LEN=4): a cycle-indexed schedule of expected
// outputs built from the frame timing rules, checked every cycle.
module tb_gtp_tx_framer;
    localparam int F  = 4;
    localparam int CW = 10;
    localparam int N  = 4096;

    logic          gtp_clk     = 1'b0;
    logic          reset_n     = 1'b0;
    logic          link_ready  = 1'b0;
    logic [CW-1:0] fifo_count  = '0;
    logic [15:0]   fifo_dout   = 16'h0000;
    logic          fifo_rd_en;
    logic [15:0]   txdata;
    logic [1:0]    txcharisk;
    logic          busy;
    logic [15:0]   frames_sent;
    logic [1:0]    dbg_state;

    always #5 gtp_clk = ~gtp_clk;

    gtp_tx_framer #(.FRAME_LEN(F), .CNT_W(CW)) dut (
        .gtp_clk     (gtp_clk),
        .reset_n     (reset_n),
        .link_ready  (link_ready),
        .fifo_count  (fifo_count),
        .fifo_dout   (fifo_dout),
        .fifo_rd_en  (fifo_rd_en),
        .txdata      (txdata),
        .txcharisk   (txcharisk),
        .busy        (busy),
        .frames_sent (frames_sent),
        .dbg_state_o (dbg_state)
    );

    int total = 0;
    int bad   = 0;

    logic [15:0] f_q[$];
    logic [15:0] exp_q[$];

    int          cyc = 0;
    int          e_kind[N];
    logic [15:0] e_word[N];
    bit          e_rd[N];
    bit          e_inc[N];
    int          next_ok   = 0;
    int          since_rst = 0;
    logic [15:0] m_frames  = 16'd0;

    logic [17:0] cap_q[$];
    int          sof_cyc_q[$];
    int          rd_seen   = 0;
    int          busy_seen = 0;
    int          sof_cnt   = 0;
    int          last_sof  = -1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    // FIFO stand-in plus the frame model: a start decision at edge k fills in
    // what every following cycle of that frame must look like.
    always @(posedge gtp_clk) begin
        if (fifo_rd_en) begin
            if (f_q.size() > 0) fifo_dout <= f_q.pop_front();
            else fifo_dout <= 16'h0000;
        end
        cyc = cyc + 1;
        if (!reset_n) begin
            since_rst = 0;
            m_frames  = 16'd0;
            next_ok   = 0;
            for (int i = 0; i < 16; i++) begin
                if (cyc + i < N) begin
                    e_kind[cyc+i] = 0;
                    e_rd[cyc+i]   = 1'b0;
                    e_inc[cyc+i]  = 1'b0;
                end
            end
        end else begin
            since_rst++;
            if (cyc < N - 16) begin
                if (e_inc[cyc]) m_frames = m_frames + 16'd1;
                if (since_rst >= 3 && cyc >= next_ok && link_ready && fifo_count >= CW'(F)) begin
                    for (int i = 0; i < F; i++) e_rd[cyc+i] = 1'b1;
                    e_kind[cyc+1] = 1;
                    for (int i = 0; i < F; i++) begin
                        e_kind[cyc+2+i] = 2;
                        if (exp_q.size() > 0) e_word[cyc+2+i] = exp_q.pop_front();
                        else e_word[cyc+2+i] = 16'h0000;
                    end
                    e_kind[cyc+F+2] = 3;
                    e_inc[cyc+F+3]  = 1'b1;
                    next_ok = cyc + F + 3;
                end
            end
        end
    end

    always @(negedge gtp_clk) begin
        logic [15:0] w_tx;
        logic [1:0]  w_k;
        int          kind;
        kind = (cyc < N) ? e_kind[cyc] : 0;
        case (kind)
            1:       begin w_tx = 16'h00FB;    w_k = 2'b01; end
            2:       begin w_tx = e_word[cyc]; w_k = 2'b00; end
            3:       begin w_tx = 16'h00FD;    w_k = 2'b01; end
            default: begin w_tx = 16'h50BC;    w_k = 2'b01; end
        endcase
        chk("txdata", 32'(txdata), 32'(w_tx));
        chk("txcharisk", 32'(txcharisk), 32'(w_k));
        chk("busy", 32'(busy), 32'(kind != 0));
        chk("fifo_rd_en", 32'(fifo_rd_en), 32'((cyc < N) ? e_rd[cyc] : 1'b0));
        chk("frames_sent", 32'(frames_sent), 32'(m_frames));
        if (busy) begin
            cap_q.push_back({txcharisk, txdata});
            busy_seen++;
        end
        if (fifo_rd_en) rd_seen++;
        if (txdata == 16'h00FB && txcharisk == 2'b01) begin
            sof_cnt++;
            last_sof = cyc;
            sof_cyc_q.push_back(cyc);
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge gtp_clk);
        #1;
    endtask

    task automatic load_both(input logic [15:0] w);
        f_q.push_back(w);
        exp_q.push_back(w);
    endtask

    task automatic load_rand(input int n);
        for (int i = 0; i < n; i++) load_both(16'($urandom_range(0, 65535)));
    endtask

    task automatic wait_sof(input int limit, input string name);
        int  s0;
        bit  got;
        s0  = sof_cnt;
        got = 1'b0;
        for (int i = 0; i < limit && !got; i++) begin
            wait_cyc(1);
            if (sof_cnt != s0) got = 1'b1;
        end
        chk(name, 32'(got), 32'd1);
    endtask

    initial begin
        logic [17:0] want[6] = '{18'h100FB, 18'h01111, 18'h02222, 18'h03333, 18'h04444, 18'h100FD};
        int c0;
        int rd0;
        int busy0;
        int sof0;

        // Reset, then link down with plenty of FIFO data.
        fifo_count = CW'(10);
        wait_cyc(3);
        reset_n = 1'b1;
        rd0 = rd_seen;
        busy0 = busy_seen;
        wait_cyc(50);
        chk("link_down_rd_en", 32'(rd_seen - rd0), 32'd0);
        chk("link_down_busy", 32'(busy_seen - busy0), 32'd0);
        chk("link_down_idle_word", 32'({txcharisk, txdata}), 32'h150BC);

        // Single frame with known payload.
        load_both(16'h1111);
        load_both(16'h2222);
        load_both(16'h3333);
        load_both(16'h4444);
        cap_q.delete();
        rd0 = rd_seen;
        link_ready = 1'b1;
        fifo_count = CW'(4);
        wait_cyc(1);
        fifo_count = CW'(0);
        wait_cyc(14);
        chk("frame1_rd_cycles", 32'(rd_seen - rd0), 32'd4);
        chk("frame1_len", 32'(cap_q.size()), 32'd6);
        for (int i = 0; i < 6; i++) begin
            if (i < cap_q.size()) chk("frame1_word", 32'(cap_q[i]), 32'(want[i]));
        end
        chk("frame1_count", 32'(frames_sent), 32'd1);
        load_rand(500);

        // One word short of a frame, then exactly enough.
        rd0 = rd_seen;
        busy0 = busy_seen;
        fifo_count = CW'(3);
        wait_cyc(20);
        chk("short_rd_en", 32'(rd_seen - rd0), 32'd0);
        chk("short_busy", 32'(busy_seen - busy0), 32'd0);
        fifo_count = CW'(4);
        c0 = cyc;
        wait_sof(10, "short_then_sof");
        fifo_count = CW'(0);
        chk("sof_latency", 32'(last_sof - c0), 32'd2);
        wait_cyc(10);
        chk("frame2_count", 32'(frames_sent), 32'd2);

        // Link drops right after SOF: frame completes, nothing new starts.
        fifo_count = CW'(4);
        wait_sof(10, "drop_sof");
        sof0 = sof_cnt;
        wait_cyc(1);
        link_ready = 1'b0;
        wait_cyc(25);
        chk("drop_no_new_sof", 32'(sof_cnt - sof0), 32'd0);
        chk("drop_count", 32'(frames_sent), 32'd3);

        // Back-to-back frames with a deep FIFO.
        sof_cyc_q.delete();
        link_ready = 1'b1;
        fifo_count = CW'(12);
        wait_cyc(15);
        fifo_count = CW'(0);
        wait_cyc(15);
        chk("b2b_sofs", 32'(sof_cyc_q.size()), 32'd3);
        for (int i = 1; i < sof_cyc_q.size(); i++) begin
            chk("b2b_spacing", 32'(sof_cyc_q[i] - sof_cyc_q[i-1]), 32'(F + 3));
        end
        chk("b2b_count", 32'(frames_sent), 32'd6);

        // Reset during payload word 2.
        fifo_count = CW'(4);
        wait_sof(10, "rst_sof");
        fifo_count = CW'(0);
        wait_cyc(3);
        reset_n = 1'b0;
        link_ready = 1'b0;
        #1;
        chk("rst_txdata", 32'(txdata), 32'h50BC);
        chk("rst_charisk", 32'(txcharisk), 32'h1);
        chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_frames", 32'(frames_sent), 32'd0);
        f_q.delete();
        exp_q.delete();
        load_rand(500);
        wait_cyc(3);
        reset_n = 1'b1;
        wait_cyc(5);
        link_ready = 1'b1;
        fifo_count = CW'(4);
        wait_sof(10, "post_rst_sof");
        fifo_count = CW'(0);
        wait_cyc(12);
        chk("post_rst_count", 32'(frames_sent), 32'd1);

        // Random link/level traffic.
        for (int i = 0; i < 1500; i++) begin
            link_ready = ($urandom_range(0, 3) != 0);
            fifo_count = CW'($urandom_range(0, 8));
            if (f_q.size() < 100) load_rand(200);
            wait_cyc(1);
        end
        link_ready = 1'b0;
        fifo_count = CW'(0);
        wait_cyc(12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
